// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART definitions for the TX and RX paths:
//             frame state encoding, frame constants and the parity helper.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Start + 8 data + parity + stop
   localparam int FRAME_BITS         = 11;
   localparam int DEFAULT_OVERSAMPLE = 16;
   // Widest payload the parity helper accepts; narrower data is zero-padded
   localparam int MAX_DATA_BITS      = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Even parity is the XOR of the payload; odd parity inverts it.
   // Zero padding does not change the XOR.
   function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic                     odd);
      return (^data) ^ odd;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : Small synchronous FIFO in front of the UART serialiser.
//             DEPTH must be a power of two so the pointers wrap naturally.
//             Push when full and pop when empty are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] c_DEPTH = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push   = push && !full;
   assign w_pop    = pop && !empty;
   assign full     = (r_count == c_DEPTH);
   assign empty    = (r_count == '0);
   assign pop_data = r_mem[r_rd_ptr];

   // Storage needs no reset: the pointers alone define which entries are valid
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
            2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Brief    : UART transmitter. Serialises each byte as start, DATA_BITS data
//             bits LSB first, parity, stop. Every bit lasts OVERSAMPLE pulses
//             of the shared baud_tick enable.
//             Optional macro UART_TX_FIFO_EN adds a 4-entry input FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_tick,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  c_BIT_LAST  = BIT_W'(DATA_BITS - 1);

   uart_state_e            r_state;
   logic [TICK_W-1:0]      r_tick_cnt;
   logic [BIT_W-1:0]       r_bit_cnt;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_parity;
   logic                   r_tx;
   logic                   r_busy;
   logic                   r_done;

   logic                   w_load;
   logic [DATA_BITS-1:0]   w_load_data;
   logic                   w_bit_end;
   logic [DATA_BITS-1:0]   w_shift_next;
   logic [MAX_DATA_BITS-1:0] w_par_in;

`ifdef UART_TX_FIFO_EN
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic                 w_push;
   logic [DATA_BITS-1:0] w_fifo_head;

   // Source side only sees the FIFO; the serialiser drains it whenever idle
   assign w_push      = tx_valid && !w_fifo_full;
   assign tx_ready    = !w_fifo_full;
   assign w_load      = (r_state == IDLE) && !w_fifo_empty;
   assign w_load_data = w_fifo_head;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (4)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (tx_data),
      .pop       (w_load),
      .pop_data  (w_fifo_head),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty)
   );
`else
   assign tx_ready    = (r_state == IDLE);
   assign w_load      = (r_state == IDLE) && tx_valid;
   assign w_load_data = tx_data;
`endif

   assign w_bit_end    = baud_tick && (r_tick_cnt == c_TICK_LAST);
   assign w_shift_next = r_shift >> 1;

   // Zero-pad the incoming byte to the width the parity helper expects
   always_comb begin
      w_par_in                = '0;
      w_par_in[DATA_BITS-1:0] = w_load_data;
   end

   assign tx      = r_tx;
   assign tx_busy = r_busy;
   assign tx_done = r_done;

   // Frame sequencer: bit timing, shifting and registered line outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;

         // Ticks only advance inside a frame; the counter restarts at every bit
         if (r_state != IDLE && baud_tick) begin
            r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + TICK_W'(1);
         end

         case (r_state)
            IDLE: begin
               if (w_load) begin
                  r_shift    <= w_load_data;
                  r_parity   <= parity_bit(w_par_in, PARITY_ODD);
                  r_tick_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_tx       <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= START;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_tx    <= r_shift[0];
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_shift <= w_shift_next;
                  if (r_bit_cnt == c_BIT_LAST) begin
                     r_tx    <= r_parity;
                     r_state <= PARITY;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                     r_tx      <= w_shift_next[0];
                  end
               end
            end
            PARITY: begin
               if (w_bit_end) begin
                  r_tx    <= 1'b1;
                  r_state <= STOP;
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
